// File: rtl/spi_debug_slave.sv
// SPI mode-0 debug responder: oversampled command/data byte pairs drive LUT/IMEM write strobes,
// core reset and clock config. Optional status read (0x80) built only with SPI_DBG_STATUS_EN.
module spi_debug_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ADDR_W      = 7
) (
  input  logic              i_nano_clk,
  input  logic              i_nano_rst,
  input  logic              i_dbg_spi_en_n,
  input  logic              i_dbg_spi_sclk,
  input  logic              i_dbg_spi_mosi,
  output logic              o_dbg_spi_miso,
  input  logic [7:0]        i_ctrl_val,
  output logic              o_core_rst,
  output logic [7:0]        o_clk_cfg,
  output logic              o_wr_en,
  output logic [2:0]        o_wr_sel,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA, S_DONE} state_t;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_en_n_sync;
  logic                   r_sclk_d;

  state_t              r_state;
  logic                r_armed;
  logic [2:0]          r_bit_cnt;
  logic [6:0]          r_rx_sr;
  logic [7:0]          r_tx_sr;
  logic [7:0]          r_cmd;
  logic [ADDR_W-1:0]   r_addr_cnt;
  logic                r_miso;
  logic                r_core_rst;
  logic [7:0]          r_clk_cfg;
  logic                r_wr_en;
  logic [2:0]          r_wr_sel;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [7:0]          r_wr_data;

  logic       w_sclk;
  logic       w_mosi;
  logic       w_en_n;
  logic       w_rise;
  logic       w_fall;
  logic [7:0] w_byte;
  logic [7:0] w_rd_val;

  // en_n chain resets to "asserted" so a real high must be seen before a new frame is accepted
  always_ff @(posedge i_nano_clk or posedge i_nano_rst) begin
    if (i_nano_rst) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_en_n_sync <= '0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_dbg_spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_dbg_spi_mosi};
      r_en_n_sync <= {r_en_n_sync[SYNC_STAGES-2:0], i_dbg_spi_en_n};
      r_sclk_d    <= w_sclk;
    end
  end

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_en_n = r_en_n_sync[SYNC_STAGES-1];
  assign w_rise = w_sclk & ~r_sclk_d;
  assign w_fall = ~w_sclk & r_sclk_d;
  assign w_byte = {r_rx_sr, w_mosi};

  // Read value selected by the command byte as it completes
  always_comb begin
    w_rd_val = 8'h00;
    case (w_byte)
      8'h90: w_rd_val = i_ctrl_val;
`ifdef SPI_DBG_STATUS_EN
      8'h80: w_rd_val = {r_core_rst, r_wr_sel, r_addr_cnt[3:0]};
`endif
      default: w_rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge i_nano_clk or posedge i_nano_rst) begin
    if (i_nano_rst) begin
      r_state    <= S_IDLE;
      r_armed    <= 1'b0;
      r_bit_cnt  <= 3'd0;
      r_rx_sr    <= 7'd0;
      r_tx_sr    <= 8'h00;
      r_cmd      <= 8'h00;
      r_addr_cnt <= '0;
      r_miso     <= 1'b0;
      r_core_rst <= 1'b0;
      r_clk_cfg  <= 8'h00;
      r_wr_en    <= 1'b0;
      r_wr_sel   <= 3'd0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'h00;
    end else begin
      r_wr_en <= 1'b0;
      if (r_wr_en) r_addr_cnt <= r_addr_cnt + ADDR_W'(1);
      if (w_en_n) r_armed <= 1'b1;

      if (w_en_n && (r_state != S_IDLE)) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 3'd0;
        r_tx_sr   <= 8'h00;
        r_miso    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_bit_cnt <= 3'd0;
            r_tx_sr   <= 8'h00;
            r_miso    <= 1'b0;
            if (!w_en_n && r_armed) r_state <= S_CMD;
          end
          S_CMD, S_WDATA, S_RDATA: begin
            if (w_rise) begin
              r_rx_sr   <= w_byte[6:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                case (r_state)
                  S_CMD: begin
                    r_cmd <= w_byte;
                    if (w_byte[7]) begin
                      r_state <= S_RDATA;
                      r_tx_sr <= w_rd_val;
                    end else begin
                      r_state <= S_WDATA;
                      r_tx_sr <= 8'h00;
                    end
                  end
                  S_WDATA: begin
                    r_state <= S_DONE;
                    case (r_cmd)
                      8'h00: begin
                        r_core_rst <= w_byte[0];
                        if (w_byte[0]) r_addr_cnt <= '0;
                      end
                      8'h20: r_clk_cfg <= w_byte;
                      8'h30, 8'h60, 8'h70, 8'h71: begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr_cnt;
                        r_wr_data <= w_byte;
                        case (r_cmd)
                          8'h60:   r_wr_sel <= 3'd0;
                          8'h70:   r_wr_sel <= 3'd1;
                          8'h71:   r_wr_sel <= 3'd2;
                          default: r_wr_sel <= 3'd3;
                        endcase
                      end
                      default: ;
                    endcase
                  end
                  default: begin
                    r_state <= S_DONE;
                    r_miso  <= 1'b0;
                  end
                endcase
              end
            end else if (w_fall) begin
              r_miso  <= r_tx_sr[7];
              r_tx_sr <= {r_tx_sr[6:0], 1'b0};
            end
          end
          default: begin
            r_miso <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_dbg_spi_miso = r_miso;
  assign o_core_rst     = r_core_rst;
  assign o_clk_cfg      = r_clk_cfg;
  assign o_wr_en        = r_wr_en;
  assign o_wr_sel       = r_wr_sel;
  assign o_wr_addr      = r_wr_addr;
  assign o_wr_data      = r_wr_data;

endmodule
